// File: rtl/timer_share_arbiter.sv
// Shares one down-counting delay timer between N requester FSMs using round-robin arbitration.
// Latency: decision at the IDLE edge; ARM + LEN RUN cycles + FIN pulse (LEN+3 cycles per grant incl. IDLE).
// Backpressure: losers hold REQ and wait; dropping REQ of the winner in ARM/RUN aborts with no DONE.
//
// Ports:
//   CLK    - clock, all state on rising edge
//   RESET  - synchronous active-high reset
//   REQ    - per-client request, held until DONE (drop to abort)
//   LEN    - per-client delay length, client i at [i*W +: W]
//   GNT    - one-hot grant, zero when idle
//   DONE   - one-cycle completion pulse to the granted client
//   BUSY   - high in every state except IDLE
//   COUNT  - current timer value
module timer_share_arbiter #(
  parameter int N = 2,
  parameter int W = 8
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic [N-1:0]   REQ,
  input  logic [N*W-1:0] LEN,
  output logic [N-1:0]   GNT,
  output logic [N-1:0]   DONE,
  output logic           BUSY,
  output logic [W-1:0]   COUNT
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_ARM  = 4'b0010,
    S_RUN  = 4'b0100,
    S_FIN  = 4'b1000
  } state_t;

  state_t         state_q, state_d;
  logic [IW-1:0]  g_q, g_d;
  logic [IW-1:0]  last_q, last_d;
  logic [W-1:0]   count_q, count_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [N-1:0]   done_q, done_d;
  logic           busy_q, busy_d;

  logic           sel_vld;
  logic [IW-1:0]  sel_idx;

  // Round-robin search: first requester after last, wrapping, so the most
  // recent winner is considered last.
  always_comb begin
    int idx;
    idx     = 0;
    sel_vld = 1'b0;
    sel_idx = last_q;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_q) + k) % N;
      if (!sel_vld && REQ[idx]) begin
        sel_vld = 1'b1;
        sel_idx = IW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    last_d  = last_q;
    count_d = count_q;

    case (state_q)
      S_IDLE: begin
        if (sel_vld) begin
          state_d = S_ARM;
          g_d     = sel_idx;
          last_d  = sel_idx;
          count_d = LEN[int'(sel_idx)*W +: W];
        end
      end
      S_ARM: begin
        if (!REQ[g_q]) begin
          state_d = S_IDLE;
          count_d = '0;
        end else if (count_q != '0) begin
          state_d = S_RUN;
        end else begin
          state_d = S_FIN;
        end
      end
      S_RUN: begin
        if (!REQ[g_q]) begin
          state_d = S_IDLE;
          count_d = '0;
        end else if (count_q <= W'(1)) begin
          // COUNT==1 is the last RUN cycle; the <= also keeps a stray zero from wrapping.
          state_d = S_FIN;
          count_d = '0;
        end else begin
          count_d = count_q - W'(1);
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        count_d = '0;
      end
    endcase

    // Outputs are registered, derived from the state being entered.
    gnt_d  = '0;
    done_d = '0;
    if (state_d != S_IDLE) gnt_d[g_d] = 1'b1;
    if (state_d == S_FIN)  done_d[g_d] = 1'b1;
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      g_q     <= '0;
      last_q  <= IW'(N - 1);
      count_q <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      last_q  <= last_d;
      count_q <= count_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign GNT   = gnt_q;
  assign DONE  = done_q;
  assign BUSY  = busy_q;
  assign COUNT = count_q;

endmodule

// File: tb/tb_timer_share_arbiter.sv
// Testbench for timer_share_arbiter: directed scenarios plus randomized traffic
// checked against a grant-timeline model (ARM, LEN RUN cycles, FIN, IDLE).
// Inputs driven 1 time unit after the rising edge, outputs sampled there too.
module tb_timer_share_arbiter;

  localparam int N = 2;
  localparam int W = 8;

  typedef struct packed {
    logic [N-1:0] gnt;
    logic [N-1:0] done;
    logic         busy;
    logic [W-1:0] count;
  } obs_t;

  logic           CLK;
  logic           RESET;
  logic [N-1:0]   REQ;
  logic [N*W-1:0] LEN;
  logic [N-1:0]   GNT;
  logic [N-1:0]   DONE;
  logic           BUSY;
  logic [W-1:0]   COUNT;

  int checks = 0;
  int passes = 0;

  timer_share_arbiter #(.N(N), .W(W)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .REQ  (REQ),
    .LEN  (LEN),
    .GNT  (GNT),
    .DONE (DONE),
    .BUSY (BUSY),
    .COUNT(COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    REQ   = '0;
    tick();
    tick();
    RESET = 1'b0;
  endtask

  function automatic obs_t observe();
    obs_t o;
    o.gnt   = GNT;
    o.done  = DONE;
    o.busy  = BUSY;
    o.count = COUNT;
    return o;
  endfunction

  // Expected outputs j cycles after a grant of length L to client g enters ARM:
  // j=0 ARM (COUNT=L), j=1..L RUN (COUNT=L-j+1), j=L+1 FIN (DONE, COUNT=0),
  // anything else is IDLE with all outputs zero.
  function automatic obs_t expect_at(int g, int L, int j);
    obs_t e;
    e = '0;
    if (j >= 0 && j <= L + 1) begin
      e.gnt[g] = 1'b1;
      e.busy   = 1'b1;
      if (j == 0)      e.count = W'(L);
      else if (j <= L) e.count = W'(L - j + 1);
      else begin
        e.count  = '0;
        e.done[g] = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic test_reset();
    obs_t a;
    RESET = 1'b1;
    REQ   = 2'b11;
    LEN   = {8'd3, 8'd3};
    tick();
    tick();
    a = observe();
    checks++;
    if (a !== obs_t'(0)) $display("FAIL reset_outputs: got %h expected %h", a, obs_t'(0));
    else passes++;
    RESET = 1'b0;
    REQ   = '0;
    tick();
    a = observe();
    checks++;
    if (a !== obs_t'(0)) $display("FAIL reset_idle_noreq: got %h expected %h", a, obs_t'(0));
    else passes++;
  endtask

  task automatic test_single();
    obs_t a, e;
    REQ = 2'b01;
    LEN[0 +: W] = 8'd5;
    for (int j = 0; j < 8; j++) begin
      tick();
      a = observe();
      e = expect_at(0, 5, j);
      checks++;
      if (a !== e) $display("FAIL single j=%0d: got %h expected %h", j, a, e);
      else passes++;
      if (j == 6) REQ = '0;
    end
  endtask

  task automatic test_alternate();
    obs_t a, e;
    int g, L;
    do_reset();
    REQ = 2'b11;
    LEN[0 +: W] = 8'd2;
    LEN[W +: W] = 8'd3;
    for (int k = 0; k < 4; k++) begin
      g = k % 2;
      L = (g == 0) ? 2 : 3;
      for (int j = 0; j <= L + 2; j++) begin
        tick();
        a = observe();
        e = expect_at(g, L, j);
        checks++;
        if (a !== e) $display("FAIL alternate grant=%0d j=%0d: got %h expected %h", k, j, a, e);
        else passes++;
        if (k == 3 && j == L + 1) REQ = '0;
      end
    end
  endtask

  task automatic test_len_zero();
    obs_t a, e;
    int busy_cycles;
    busy_cycles = 0;
    REQ = 2'b01;
    LEN[0 +: W] = 8'd0;
    for (int j = 0; j < 3; j++) begin
      tick();
      a = observe();
      e = expect_at(0, 0, j);
      if (a.busy) busy_cycles++;
      checks++;
      if (a !== e) $display("FAIL len_zero j=%0d: got %h expected %h", j, a, e);
      else passes++;
      if (j == 1) REQ = '0;
    end
    checks++;
    if (busy_cycles !== 2) $display("FAIL len_zero_busy: got %0d cycles expected 2", busy_cycles);
    else passes++;
  endtask

  task automatic test_abort();
    obs_t a, e;
    do_reset();
    REQ = 2'b11;
    LEN[0 +: W] = 8'd10;
    LEN[W +: W] = 8'd2;
    for (int j = 0; j <= 5; j++) begin
      tick();
      a = observe();
      e = expect_at(0, 10, j);
      checks++;
      if (a !== e) $display("FAIL abort_run j=%0d: got %h expected %h", j, a, e);
      else passes++;
    end
    REQ[0] = 1'b0;  // dropped while COUNT=6
    tick();
    a = observe();
    checks++;
    if (a !== obs_t'(0)) $display("FAIL abort_idle: got %h expected %h", a, obs_t'(0));
    else passes++;
    for (int j = 0; j <= 4; j++) begin
      tick();
      a = observe();
      e = expect_at(1, 2, j);
      checks++;
      if (a !== e) $display("FAIL abort_next_grant j=%0d: got %h expected %h", j, a, e);
      else passes++;
      if (j == 3) REQ = '0;
    end
  endtask

  task automatic test_reset_midrun();
    obs_t a, e;
    do_reset();
    REQ = 2'b01;
    LEN[0 +: W] = 8'd9;
    LEN[W +: W] = 8'd1;
    for (int j = 0; j <= 6; j++) begin
      tick();
      a = observe();
      e = expect_at(0, 9, j);
      checks++;
      if (a !== e) $display("FAIL midrun j=%0d: got %h expected %h", j, a, e);
      else passes++;
    end
    RESET = 1'b1;  // COUNT is 4 here
    tick();
    RESET = 1'b0;
    a = observe();
    checks++;
    if (a !== obs_t'(0)) $display("FAIL midrun_reset: got %h expected %h", a, obs_t'(0));
    else passes++;
    REQ = 2'b11;
    tick();
    a = observe();
    e = expect_at(0, 9, 0);
    checks++;
    if (a !== e) $display("FAIL midrun_first_winner: got %h expected %h", a, e);
    else passes++;
    REQ = 2'b10;  // abort client 0, client 1 follows
    tick();
    a = observe();
    checks++;
    if (a !== obs_t'(0)) $display("FAIL midrun_abort: got %h expected %h", a, obs_t'(0));
    else passes++;
    tick();
    a = observe();
    e = expect_at(1, 1, 0);
    checks++;
    if (a !== e) $display("FAIL midrun_second_winner: got %h expected %h", a, e);
    else passes++;
    REQ = '0;
    tick();
    tick();
  endtask

  task automatic test_len_change();
    obs_t a, e;
    REQ = 2'b01;
    LEN[0 +: W] = 8'd7;
    for (int j = 0; j <= 9; j++) begin
      tick();
      a = observe();
      e = expect_at(0, 7, j);
      checks++;
      if (a !== e) $display("FAIL len_change j=%0d: got %h expected %h", j, a, e);
      else passes++;
      if (j == 0) LEN[0 +: W] = 8'd2;
      if (j == 8) REQ = '0;
    end
  endtask

  task automatic test_random();
    obs_t a, e;
    int active, g, j, L, last, idx;
    logic [N-1:0] req;
    logic [W-1:0] lens [N];
    int grants [N];
    do_reset();
    last = N - 1;
    active = 0;
    g = 0; j = 0; L = 0;
    req = '0;
    for (int i = 0; i < N; i++) begin
      lens[i] = '0;
      grants[i] = 0;
    end
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom_range(0, 2) == 0) begin
          req[i]  = 1'b1;
          lens[i] = W'($urandom_range(0, 6));
        end else if ($urandom_range(0, 4) == 0) begin
          lens[i] = W'($urandom_range(0, 6));
        end
      end
      REQ = req;
      for (int i = 0; i < N; i++) LEN[i*W +: W] = lens[i];
      tick();
      if (active != 0) begin
        j++;
        if (j > L + 1) active = 0;
      end else begin
        for (int k = 1; k <= N; k++) begin
          idx = (last + k) % N;
          if (active == 0 && req[idx]) begin
            active = 1;
            g = idx;
            L = int'(lens[idx]);
            j = 0;
            last = idx;
            grants[idx]++;
          end
        end
      end
      a = observe();
      e = (active != 0) ? expect_at(g, L, j) : obs_t'(0);
      checks++;
      if (a !== e) $display("FAIL random cyc=%0d: got %h expected %h", cyc, a, e);
      else passes++;
      if (active != 0 && j == L + 1) begin
        if ($urandom_range(0, 1) == 0) req[g] = 1'b0;
        else lens[g] = W'($urandom_range(0, 6));
      end
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (grants[i] < 10) $display("FAIL random_coverage client=%0d: got %0d grants expected >=10", i, grants[i]);
      else passes++;
    end
    REQ = '0;
    for (int k = 0; k < 12; k++) tick();
  endtask

  initial begin
    RESET = 1'b1;
    REQ   = '0;
    LEN   = '0;
    test_reset();
    test_single();
    test_alternate();
    test_len_zero();
    test_abort();
    test_reset_midrun();
    test_len_change();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
